// File: rtl/adma_dm_pkg.sv
// Shared AXI encodings for the ADMA data mover hosts.
package adma_dm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // SLVERR and DECERR both carry bit 1.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/adma_dm_axi_w.sv
// Write-data side of the ADMA write host: burst length queue, beat counter, WLAST.
// Build macro ADMA_DM_WR_W_AFTER_AW_EN holds each burst's beats until its AW handshake.
module adma_dm_axi_w
  import adma_dm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [LEN_W-1:0] i_push_len,
  input  logic             i_aw_hs,
  input  logic             i_wvalid,
  input  logic             i_wready,
  output logic             o_wvalid,
  output logic             o_wready,
  output logic             o_wlast,
  output logic             o_full
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LEN_W-1:0] r_len [DEPTH];
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_beat;
  logic             w_empty;
  logic             w_head_ok;
  logic             w_push;
  logic             w_hs;
  logic             w_pop;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? IDX_W'(0) : p + IDX_W'(1);
  endfunction

  assign w_empty = (r_cnt == CNT_W'(0));
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_push  = i_push & ~o_full;

`ifdef ADMA_DM_WR_W_AFTER_AW_EN
  logic [DEPTH-1:0] r_issued;
  logic [IDX_W-1:0] w_aw_idx;

  // The AW register always carries the most recently pushed burst.
  assign w_aw_idx  = (r_wptr == IDX_W'(0)) ? IDX_W'(DEPTH - 1) : r_wptr - IDX_W'(1);
  assign w_head_ok = ~w_empty & r_issued[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued <= '0;
    end else begin
      if (w_push) r_issued[r_wptr] <= 1'b0;
      if (i_aw_hs) r_issued[w_aw_idx] <= 1'b1;
    end
  end
`else
  logic w_unused_aw_hs;

  assign w_unused_aw_hs = i_aw_hs;
  assign w_head_ok      = ~w_empty;
`endif

  assign o_wvalid = i_wvalid & w_head_ok;
  assign o_wready = i_wready & w_head_ok;
  assign w_hs     = i_wvalid & i_wready & w_head_ok;
  assign o_wlast  = w_head_ok & (r_beat == r_len[r_rptr]);
  assign w_pop    = w_hs & o_wlast;

  always_ff @(posedge clk) begin
    if (w_push) r_len[r_wptr] <= i_push_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_beat <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop) r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      if (w_pop) r_beat <= '0;
      else if (w_hs) r_beat <= r_beat + LEN_W'(1);
    end
  end

endmodule

// File: rtl/adma_dm_wr_host.sv
// ADMA data mover AXI4 write host: AW issue, W streaming and B decode per channel.
// Build macro ADMA_DM_WR_W_AFTER_AW_EN holds W beats until their burst's AW completes.
module adma_dm_wr_host
  import adma_dm_pkg::*;
#(
  parameter int  DMA_CHN_NUM    = 4,
  parameter int  DST_ADDR_W     = 32,
  parameter int  MST_ID_W       = 5,
  parameter int  ATX_LEN_W      = 8,
  parameter int  ATX_RESP_W     = 2,
  parameter int  ATX_DST_DATA_W = 256,
  parameter int  ATX_NUM_OSTD   = DMA_CHN_NUM,
  localparam int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DMA_CHN_NUM_W-1:0]              atx_chn_id,
  input  logic [MST_ID_W-1:0]                   atx_awid,
  input  logic [DST_ADDR_W-1:0]                 atx_awaddr,
  input  logic [ATX_LEN_W-1:0]                  atx_awlen,
  input  logic [1:0]                            atx_awburst,
  input  logic                                  atx_vld,
  output logic                                  atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]             atx_wdata,
  input  logic                                  atx_wdata_vld,
  output logic                                  atx_wdata_rdy,
  input  logic [DMA_CHN_NUM-1:0][MST_ID_W-1:0]  atx_id,
  output logic [DMA_CHN_NUM-1:0]                atx_done,
  output logic [DMA_CHN_NUM-1:0]                atx_dst_err,
  output logic [MST_ID_W-1:0]                   m_awid_o,
  output logic [DST_ADDR_W-1:0]                 m_awaddr_o,
  output logic [ATX_LEN_W-1:0]                  m_awlen_o,
  output logic [1:0]                            m_awburst_o,
  output logic                                  m_awvalid_o,
  input  logic                                  m_awready_i,
  output logic [ATX_DST_DATA_W-1:0]             m_wdata_o,
  output logic [ATX_DST_DATA_W/8-1:0]           m_wstrb_o,
  output logic                                  m_wlast_o,
  output logic                                  m_wvalid_o,
  input  logic                                  m_wready_i,
  input  logic [MST_ID_W-1:0]                   m_bid_i,
  input  logic [ATX_RESP_W-1:0]                 m_bresp_i,
  input  logic                                  m_bvalid_i,
  output logic                                  m_bready_o
);

  localparam int OSTD_W = $clog2(ATX_NUM_OSTD + 1);

  logic                   r_aw_vld;
  logic [MST_ID_W-1:0]    r_awid;
  logic [DST_ADDR_W-1:0]  r_awaddr;
  logic [ATX_LEN_W-1:0]   r_awlen;
  logic [1:0]             r_awburst;
  logic [OSTD_W-1:0]      r_ostd;
  logic                   r_bready;
  logic [DMA_CHN_NUM-1:0] r_done;
  logic [DMA_CHN_NUM-1:0] r_err;
  logic                   w_q_full;
  logic                   w_accept;
  logic                   w_aw_hs;
  logic                   w_b_hs;
  logic                   w_ostd_dec;
  logic [DMA_CHN_NUM-1:0] w_bid_match;
  logic                   w_unused;

  assign w_unused = ^atx_chn_id;

  // r_bready doubles as the "out of reset" qualifier so atx_rdy is 0 while in reset.
  assign atx_rdy    = r_bready & (~r_aw_vld | m_awready_i) & ~w_q_full &
                      (r_ostd < OSTD_W'(ATX_NUM_OSTD));
  assign w_accept   = atx_vld & atx_rdy;
  assign w_aw_hs    = r_aw_vld & m_awready_i;
  assign w_b_hs     = m_bvalid_i & r_bready;
  assign w_ostd_dec = w_b_hs & (r_ostd != OSTD_W'(0));

  assign m_awvalid_o = r_aw_vld;
  assign m_awid_o    = r_awid;
  assign m_awaddr_o  = r_awaddr;
  assign m_awlen_o   = r_awlen;
  assign m_awburst_o = r_awburst;
  assign m_wdata_o   = atx_wdata;
  assign m_wstrb_o   = '1;
  assign m_bready_o  = r_bready;
  assign atx_done    = r_done;
  assign atx_dst_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_vld  <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awburst <= '0;
    end else if (w_accept) begin
      r_aw_vld  <= 1'b1;
      r_awid    <= atx_awid;
      r_awaddr  <= atx_awaddr;
      r_awlen   <= atx_awlen;
      r_awburst <= atx_awburst;
    end else if (w_aw_hs) begin
      r_aw_vld  <= 1'b0;
    end
  end

  // A B response with nothing outstanding is dropped from the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ostd   <= '0;
      r_bready <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      if (w_accept && !w_ostd_dec) r_ostd <= r_ostd + OSTD_W'(1);
      else if (!w_accept && w_ostd_dec) r_ostd <= r_ostd - OSTD_W'(1);
    end
  end

  always_comb begin
    w_bid_match = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      w_bid_match[i] = (m_bid_i == atx_id[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= '0;
      r_err  <= '0;
    end else begin
      r_done <= w_b_hs ? w_bid_match : '0;
      if (w_b_hs && resp_is_err(m_bresp_i)) r_err <= r_err | w_bid_match;
    end
  end

  adma_dm_axi_w #(
    .DEPTH (ATX_NUM_OSTD),
    .LEN_W (ATX_LEN_W)
  ) u_axi_w (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_push_len (atx_awlen),
    .i_aw_hs    (w_aw_hs),
    .i_wvalid   (atx_wdata_vld),
    .i_wready   (m_wready_i),
    .o_wvalid   (m_wvalid_o),
    .o_wready   (atx_wdata_rdy),
    .o_wlast    (m_wlast_o),
    .o_full     (w_q_full)
  );

endmodule

// File: tb/tb_adma_dm_wr_host.sv
// Self-checking bench for adma_dm_wr_host: W scoreboard, B-decode vector table, corner sequences.
module tb_adma_dm_wr_host;
  import adma_dm_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int IDW = 5;
  localparam int LW  = 8;
  localparam int DW  = 256;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [IDW-1:0] bid;
    logic [1:0]     resp;
    logic [NCH-1:0] exp_done;
    logic [NCH-1:0] exp_err;
  } bvec_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [1:0]                atx_chn_id = 2'd0;
  logic [IDW-1:0]            atx_awid = '0;
  logic [AW-1:0]             atx_awaddr = '0;
  logic [LW-1:0]             atx_awlen = '0;
  logic [1:0]                atx_awburst = 2'b01;
  logic                      atx_vld = 1'b0;
  logic                      atx_rdy;
  logic [DW-1:0]             atx_wdata;
  logic                      atx_wdata_vld;
  logic                      atx_wdata_rdy;
  logic [NCH-1:0][IDW-1:0]   atx_id;
  logic [NCH-1:0]            atx_done;
  logic [NCH-1:0]            atx_dst_err;
  logic [IDW-1:0]            m_awid_o;
  logic [AW-1:0]             m_awaddr_o;
  logic [LW-1:0]             m_awlen_o;
  logic [1:0]                m_awburst_o;
  logic                      m_awvalid_o;
  logic                      m_awready_i = 1'b1;
  logic [DW-1:0]             m_wdata_o;
  logic [DW/8-1:0]           m_wstrb_o;
  logic                      m_wlast_o;
  logic                      m_wvalid_o;
  logic                      m_wready_i = 1'b1;
  logic [IDW-1:0]            m_bid_i = '0;
  logic [1:0]                m_bresp_i = 2'b00;
  logic                      m_bvalid_i = 1'b0;
  logic                      m_bready_o;

  beat_t wq[$];
  bvec_t bt[6];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beats_seen = 0;
  int    lasts_seen = 0;

  adma_dm_wr_host dut (
    .clk(clk), .rst(rst), .atx_chn_id(atx_chn_id), .atx_awid(atx_awid),
    .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_wdata(atx_wdata),
    .atx_wdata_vld(atx_wdata_vld), .atx_wdata_rdy(atx_wdata_rdy), .atx_id(atx_id),
    .atx_done(atx_done), .atx_dst_err(atx_dst_err), .m_awid_o(m_awid_o),
    .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i), .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [LW-1:0] len);
    beat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = {8{$urandom()}};
      b.last = (i == int'(len));
      wq.push_back(b);
    end
  endtask

  task automatic issue(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int waited;
    waited = 0;
    atx_awid = id; atx_awaddr = addr; atx_awlen = len; atx_awburst = BURST_INCR; atx_vld = 1'b1;
    push_beats(len);
    while (!atx_rdy && waited < 50) begin
      tick();
      waited++;
    end
    if (!atx_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: atx_rdy=0 required 1 (addr %0h)", addr);
      atx_vld = 1'b0;
    end else begin
      tick();
      atx_vld = 1'b0;
      chk("aw_valid_after_accept", m_awvalid_o, 1'b1);
      chk("aw_addr_after_accept", m_awaddr_o, addr);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (wq.size() > 0 && t < 200) begin
      tick();
      t++;
    end
    if (wq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL w_drain_timeout: %0d beats pending required 0", wq.size());
      wq.delete();
    end
  endtask

  task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] resp);
    m_bvalid_i = 1'b1; m_bid_i = id; m_bresp_i = resp;
    tick();
    m_bvalid_i = 1'b0;
  endtask

  // Beat source: presents the scoreboard head as the next write beat.
  initial begin
    atx_wdata = '0;
    atx_wdata_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wq.size() > 0) begin
        atx_wdata = wq[0].data;
        atx_wdata_vld = 1'b1;
      end else begin
        atx_wdata_vld = 1'b0;
      end
    end
  end

  // W monitor: every beat handshake pops and checks the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_wvalid_o && m_wready_i) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w_unexpected_beat: beat seen with scoreboard empty, required none");
      end else begin
        chk("w_data", m_wdata_o, wq[0].data);
        chk("w_last", m_wlast_o, wq[0].last);
        beats_seen++;
        if (m_wlast_o) lasts_seen++;
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    int b0;
    int l0;
    atx_id = {5'd9, 5'd9, 5'd2, 5'd1};
    bt[0] = '{bid: 5'd2,  resp: RESP_OKAY,   exp_done: 4'b0010, exp_err: 4'b0000};
    bt[1] = '{bid: 5'd9,  resp: RESP_SLVERR, exp_done: 4'b1100, exp_err: 4'b1100};
    bt[2] = '{bid: 5'd9,  resp: RESP_OKAY,   exp_done: 4'b1100, exp_err: 4'b1100};
    bt[3] = '{bid: 5'd1,  resp: RESP_DECERR, exp_done: 4'b0001, exp_err: 4'b1101};
    bt[4] = '{bid: 5'd20, resp: RESP_SLVERR, exp_done: 4'b0000, exp_err: 4'b1101};
    bt[5] = '{bid: 5'd2,  resp: RESP_EXOKAY, exp_done: 4'b0010, exp_err: 4'b1101};

    repeat (3) tick();
    chk("rst_awvalid", m_awvalid_o, 1'b0);
    chk("rst_awaddr", m_awaddr_o, 32'd0);
    chk("rst_awid_len", {m_awid_o, m_awlen_o, m_awburst_o}, 15'd0);
    chk("rst_wvalid", m_wvalid_o, 1'b0);
    chk("rst_wlast", m_wlast_o, 1'b0);
    chk("rst_bready", m_bready_o, 1'b0);
    chk("rst_atx_rdy", atx_rdy, 1'b0);
    chk("rst_wdata_rdy", atx_wdata_rdy, 1'b0);
    chk("rst_done", atx_done, 4'b0000);
    chk("rst_err", atx_dst_err, 4'b0000);
    rst = 1'b0;
    tick();
    chk("bready_after_rst", m_bready_o, 1'b1);
    chk("atx_rdy_after_rst", atx_rdy, 1'b1);
    chk("wstrb_all_ones", m_wstrb_o, {(DW/8){1'b1}});

    // Single INCR burst, 4 beats, OKAY on channel 1's ID.
    b0 = beats_seen; l0 = lasts_seen;
    issue(5'd2, 32'h0000_1000, 8'd3);
    wait_drain();
    chk("t1_beats", beats_seen - b0, 4);
    chk("t1_lasts", lasts_seen - l0, 1);
    chk("t1_aw_idle", m_awvalid_o, 1'b0);
    send_b(5'd2, RESP_OKAY);
    chk("t1_done", atx_done, 4'b0010);
    chk("t1_err", atx_dst_err, 4'b0000);
    tick();
    chk("t1_done_one_cycle", atx_done, 4'b0000);

    // awlen=0: a single beat carrying wlast.
    b0 = beats_seen; l0 = lasts_seen;
    issue(5'd1, 32'h0000_2000, 8'd0);
    wait_drain();
    chk("t2_beats", beats_seen - b0, 1);
    chk("t2_lasts", lasts_seen - l0, 1);
    send_b(5'd1, RESP_OKAY);
    chk("t2_done", atx_done, 4'b0001);

    // Outstanding limit: 4 accepted, 5th held until a B arrives.
    for (int k = 0; k < 4; k++) issue(5'd1, 32'h0000_3000 + 32'(k * 64), 8'd1);
    wait_drain();
    chk("t3_rdy_at_limit", atx_rdy, 1'b0);
    atx_awid = 5'd1; atx_awaddr = 32'h0000_3100; atx_awlen = 8'd1; atx_vld = 1'b1;
    push_beats(8'd1);
    tick();
    chk("t3_rdy_still_low", atx_rdy, 1'b0);
    m_bvalid_i = 1'b1; m_bid_i = 5'd1; m_bresp_i = RESP_OKAY;
    chk("t3_rdy_low_during_b", atx_rdy, 1'b0);
    tick();
    m_bvalid_i = 1'b0;
    chk("t3_done", atx_done, 4'b0001);
    chk("t3_rdy_after_b", atx_rdy, 1'b1);
    tick();
    atx_vld = 1'b0;
    chk("t3_aw_5th", m_awaddr_o, 32'h0000_3100);
    chk("t3_rdy_full_again", atx_rdy, 1'b0);
    send_b(5'd1, RESP_OKAY);
    chk("t3_done_b2", atx_done, 4'b0001);

    // Accept and B in the same cycle leave the count unchanged at 3.
    atx_awid = 5'd1; atx_awaddr = 32'h0000_3200; atx_awlen = 8'd0; atx_vld = 1'b1;
    push_beats(8'd0);
    m_bvalid_i = 1'b1; m_bid_i = 5'd1; m_bresp_i = RESP_OKAY;
    chk("t4_rdy_before_simul", atx_rdy, 1'b1);
    tick();
    atx_vld = 1'b0; m_bvalid_i = 1'b0;
    chk("t4_done_simul", atx_done, 4'b0001);
    chk("t4_rdy_after_simul", atx_rdy, 1'b1);
    issue(5'd1, 32'h0000_3300, 8'd0);
    chk("t4_rdy_full_after_simul", atx_rdy, 1'b0);
    wait_drain();
    for (int k = 0; k < 4; k++) begin
      send_b(5'd1, RESP_OKAY);
      chk("t4_drain_done", atx_done, 4'b0001);
    end

    // B decode vectors, one single-beat burst per record.
    for (int i = 0; i < 6; i++) begin
      issue(bt[i].bid, 32'h0000_4000 + 32'(i * 32), 8'd0);
      wait_drain();
      send_b(bt[i].bid, bt[i].resp);
      chk("tab_done", atx_done, bt[i].exp_done);
      chk("tab_err", atx_dst_err, bt[i].exp_err);
      tick();
      chk("tab_done_clear", atx_done, 4'b0000);
    end
    chk("err_sticky", atx_dst_err, 4'b1101);
    rst = 1'b1;
    #1;
    chk("err_async_clear", atx_dst_err, 4'b0000);
    tick();
    rst = 1'b0;
    tick();

    // B with nothing outstanding must not disturb the count.
    send_b(5'd20, RESP_OKAY);
    chk("uflow_done", atx_done, 4'b0000);
    for (int k = 0; k < 3; k++) issue(5'd3, 32'h0000_5000 + 32'(k * 16), 8'd0);
    chk("uflow_rdy_three", atx_rdy, 1'b1);
    issue(5'd3, 32'h0000_5030, 8'd0);
    chk("uflow_rdy_four", atx_rdy, 1'b0);
    wait_drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // AW stalled for 10 cycles: payload held, W follows the build option.
    m_awready_i = 1'b0;
    b0 = beats_seen;
    issue(5'd7, 32'hABCD_0040, 8'd1);
    for (int k = 0; k < 10; k++) begin
      chk("stall_awvalid", m_awvalid_o, 1'b1);
      chk("stall_payload", {m_awid_o, m_awaddr_o, m_awlen_o, m_awburst_o},
          {5'd7, 32'hABCD_0040, 8'd1, BURST_INCR});
      chk("stall_rdy", atx_rdy, 1'b0);
      tick();
    end
`ifdef ADMA_DM_WR_W_AFTER_AW_EN
    chk("stall_no_beats", beats_seen - b0, 0);
    chk("stall_wvalid_low", m_wvalid_o, 1'b0);
`else
    chk("stall_beats_flow", beats_seen - b0, 2);
`endif
    m_awready_i = 1'b1;
    tick();
    chk("stall_aw_done", m_awvalid_o, 1'b0);
    wait_drain();
    chk("stall_total_beats", beats_seen - b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
